lbp_engine: RTL and testbench

Parametrised successor of the fixed 128x128 LBP block. It raster-scans a 2^ROW_BITS x 2^COL_BITS grey image from the external grey memory and writes one 8-bit texture code per pixel to the result memory. It adds three selectable code modes and a programmable threshold, and it honours `gray_ready` before starting. It sits between the grey-image ROM and the LBP result RAM and reuses columns so that steady-state interior pixels cost three reads each.

---
 rtl/lbp_engine_if.sv | 35 +++
 rtl/lbp_engine.sv | 266 ++++++++++++++++++++++++++
 tb/tb_lbp_engine.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lbp_engine_if                                          |
// | Description : Grey-memory read port and LBP result write port of the |
// |               texture engine, bundled for the engine and its memories|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface lbp_engine_if #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 7,
  parameter int PIX_W    = 8
);
  localparam int AW = ROW_BITS + COL_BITS;

  logic             gray_ready;
  logic [AW-1:0]    gray_addr;
  logic             gray_req;
  logic [PIX_W-1:0] gray_data;
  logic [AW-1:0]    lbp_addr;
  logic             lbp_valid;
  logic [7:0]       lbp_data;

  // Engine side: issues reads, consumes grey data, produces result writes
  modport master (
    input  gray_ready, gray_data,
    output gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data
  );

  // Memory side: grey ROM answers reads, result RAM accepts writes
  modport slave (
    output gray_ready, gray_data,
    input  gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data
  );
endinterface
`default_nettype wire

// File: rtl/lbp_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lbp_engine                                             |
// | Description : Raster-scan local binary pattern engine. Reads a grey  |
// |               image through a 3x3 sliding window (column reuse) and  |
// |               writes one 8-bit texture code per pixel (LBP, CS-LBP,  |
// |               thresholded LBP).                                      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module lbp_engine #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 7,
  parameter int PIX_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  lbp_engine_if.master     bus,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  output logic             finish
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BORDER = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_SLIDE  = 3'd3;
  localparam logic [2:0] S_CALC   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [3:0]          cnt_q, cnt_d;

  // Read pipeline: one outstanding read, slot says where the data lands
  logic                pend_q;
  logic [3:0]          pidx_q;
  logic                req;
  logic [3:0]          slot;
  logic [1:0]          win_row, win_col;
  logic [ROW_BITS-1:0] rd_row;
  logic [COL_BITS-1:0] rd_col;

  // Window stored column-major: index = 3*col_offset + row_offset
  logic [PIX_W-1:0]    win_q [9];
  logic [PIX_W-1:0]    nb    [8];

  logic [1:0]          mode_q;
  logic [PIX_W-1:0]    thresh_q;
  logic [7:0]          code_q, code_d;

  logic [ROW_BITS+COL_BITS-1:0] hold_addr_q;
  logic [7:0]                   hold_data_q;
  logic                         finish_q;

  logic                wr;
  logic [7:0]          wr_data;
  logic [COL_BITS-1:0] nxt_col;
  logic [ROW_BITS-1:0] nxt_row;
  logic                nxt_interior;
  logic                at_end;

  assign nxt_col      = col_q + COL_BITS'(1);
  assign nxt_row      = (&col_q) ? row_q + ROW_BITS'(1) : row_q;
  assign nxt_interior = (nxt_row != '0) && (nxt_row != '1) &&
                        (nxt_col != '0) && (nxt_col != '1);
  assign at_end       = (&row_q) && (&col_q);

  // Read address generation: FILL walks all 9 window slots, SLIDE only column c+1
  always_comb begin
    req     = 1'b0;
    slot    = 4'd0;
    win_row = 2'd0;
    win_col = 2'd0;
    if (state_q == S_FILL && cnt_q < 4'd9) begin
      req  = 1'b1;
      slot = cnt_q;
      if (cnt_q >= 4'd6) begin
        win_col = 2'd2;
        win_row = 2'(cnt_q - 4'd6);
      end else if (cnt_q >= 4'd3) begin
        win_col = 2'd1;
        win_row = 2'(cnt_q - 4'd3);
      end else begin
        win_col = 2'd0;
        win_row = 2'(cnt_q);
      end
    end else if (state_q == S_SLIDE && cnt_q < 4'd3) begin
      req     = 1'b1;
      slot    = 4'd6 + cnt_q;
      win_col = 2'd2;
      win_row = 2'(cnt_q);
    end
  end

  assign rd_row        = row_q + ROW_BITS'(win_row) - ROW_BITS'(1);
  assign rd_col        = col_q + COL_BITS'(win_col) - COL_BITS'(1);
  assign bus.gray_req  = req;
  assign bus.gray_addr = req ? {rd_row, rd_col} : '0;

  // Neighbour numbering g0..g7 mapped onto the column-major window
  always_comb begin
    nb[0] = win_q[0];
    nb[1] = win_q[3];
    nb[2] = win_q[6];
    nb[3] = win_q[1];
    nb[4] = win_q[7];
    nb[5] = win_q[2];
    nb[6] = win_q[5];
    nb[7] = win_q[8];
  end

  // Code evaluation for all three modes; mode 3 falls back to plain LBP
  always_comb begin
    logic [PIX_W:0] sum;
    logic [PIX_W:0] diff;
    logic [7:0]     lbp_bits;
    logic [7:0]     thr_bits;
    logic [3:0]     cs_bits;
    sum      = {1'b0, win_q[4]} + {1'b0, thresh_q};
    diff     = '0;
    lbp_bits = '0;
    thr_bits = '0;
    cs_bits  = '0;
    for (int i = 0; i < 8; i++) begin
      lbp_bits[i] = (nb[i] >= win_q[4]);
      thr_bits[i] = ({1'b0, nb[i]} >= sum);
    end
    for (int k = 0; k < 4; k++) begin
      diff       = {1'b0, nb[k]} - {1'b0, nb[7-k]};
      cs_bits[k] = ($signed(diff) > $signed({1'b0, thresh_q}));
    end
    case (mode_q)
      2'd1:    code_d = {4'b0000, cs_bits};
      2'd2:    code_d = thr_bits;
      default: code_d = lbp_bits;
    endcase
  end

  // Scan state machine and pixel position
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (bus.gray_ready) state_d = S_BORDER;
      end
      S_BORDER: begin
        cnt_d = 4'd0;
        if (at_end) begin
          state_d = S_DONE;
        end else begin
          row_d = nxt_row;
          col_d = nxt_col;
          if (nxt_interior) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (cnt_q == 4'd9) begin
          state_d = S_CALC;
          cnt_d   = 4'd0;
        end
      end
      S_SLIDE: begin
        if (cnt_q == 4'd3) begin
          state_d = S_CALC;
          cnt_d   = 4'd0;
        end
      end
      S_CALC: begin
        cnt_d   = 4'd0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d = 4'd0;
        if (at_end) begin
          state_d = S_DONE;
        end else begin
          row_d   = nxt_row;
          col_d   = nxt_col;
          state_d = nxt_interior ? S_SLIDE : S_BORDER;
        end
      end
      S_DONE: cnt_d = 4'd0;
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, position and step counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read capture into the window, plus left shift when moving to the next column
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      pidx_q <= 4'd0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      pend_q <= req;
      pidx_q <= slot;
      if (state_q == S_WRITE && state_d == S_SLIDE) begin
        for (int i = 0; i < 6; i++) win_q[i] <= win_q[i+3];
      end
      if (pend_q) win_q[pidx_q] <= bus.gray_data;
    end
  end

  // Frame configuration latched at scan start, code latched in CALC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= 2'd0;
      thresh_q <= '0;
      code_q   <= 8'd0;
    end else begin
      if (state_q == S_IDLE && bus.gray_ready) begin
        mode_q   <= mode;
        thresh_q <= thresh;
      end
      if (state_q == S_CALC) code_q <= code_d;
    end
  end

  assign wr      = (state_q == S_BORDER) || (state_q == S_WRITE);
  assign wr_data = (state_q == S_WRITE) ? code_q : 8'd0;

  // Last written address/data held so the write port is stable between strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_addr_q <= '0;
      hold_data_q <= 8'd0;
      finish_q    <= 1'b0;
    end else begin
      if (wr) begin
        hold_addr_q <= {row_q, col_q};
        hold_data_q <= wr_data;
      end
      if (state_d == S_DONE) finish_q <= 1'b1;
    end
  end

  assign bus.lbp_valid = wr;
  assign bus.lbp_addr  = wr ? {row_q, col_q} : hold_addr_q;
  assign bus.lbp_data  = wr ? wr_data : hold_data_q;
  assign finish        = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_lbp_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_lbp_engine                                          |
// | Description : Self-checking bench for lbp_engine on an 8x8 image     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_lbp_engine;
  localparam int CB = 3;
  localparam int RB = 3;
  localparam int PW = 8;
  localparam int W  = 1 << CB;
  localparam int H  = 1 << RB;
  localparam int N  = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] thresh = 8'd0;
  logic       finish;

  lbp_engine_if #(.COL_BITS(CB), .ROW_BITS(RB), .PIX_W(PW)) bus ();

  lbp_engine #(.COL_BITS(CB), .ROW_BITS(RB), .PIX_W(PW)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .mode   (mode),
    .thresh (thresh),
    .finish (finish)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [N];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int req_addr_q[$];
  int req_t_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_t_q[$];
  int hold_viol;
  int req_in_wr;
  int fin_t;
  logic fin_prev;
  logic [CB+RB-1:0] prev_addr;
  logic [7:0] prev_data;

  // Grey ROM: data one cycle after a request, garbage otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.gray_data <= bus.gray_req ? mem[bus.gray_addr] : 8'($urandom);
  end

  // Bus monitor sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      if (bus.gray_req) begin
        req_addr_q.push_back(int'(bus.gray_addr));
        req_t_q.push_back(cyc);
        if (bus.lbp_valid) req_in_wr++;
      end
      if (bus.lbp_valid) begin
        wr_addr_q.push_back(int'(bus.lbp_addr));
        wr_data_q.push_back(int'(bus.lbp_data));
        wr_t_q.push_back(cyc);
      end else if (bus.lbp_addr !== prev_addr || bus.lbp_data !== prev_data) begin
        hold_viol++;
      end
      if (finish && !fin_prev) fin_t = cyc;
    end
    fin_prev  = finish;
    prev_addr = bus.lbp_addr;
    prev_data = bus.lbp_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    req_addr_q.delete();
    req_t_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_t_q.delete();
    hold_viol = 0;
    req_in_wr = 0;
    fin_t = -1;
  endtask

  task automatic fill_mem(input int kind);
    for (int i = 0; i < N; i++) begin
      if (kind == 0)      mem[i] = 8'($urandom);
      else if (kind == 1) mem[i] = 8'($urandom_range(52, 48));
      else                mem[i] = 8'd50;
    end
  endtask

  // Reference: texture code of pixel (r,c) straight from the neighbourhood rules
  function automatic int exp_code(input int r, input int c, input int m, input int th);
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int g[8];
    int gc;
    int code;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    gc = int'(mem[r*W + c]);
    code = 0;
    for (int i = 0; i < 8; i++) g[i] = int'(mem[(r+dr[i])*W + c + dc[i]]);
    if (m == 1) begin
      for (int k = 0; k < 4; k++) if (g[k] - g[7-k] > th) code |= (1 << k);
    end else if (m == 2) begin
      for (int i = 0; i < 8; i++) if (g[i] >= gc + th) code |= (1 << i);
    end else begin
      for (int i = 0; i < 8; i++) if (g[i] >= gc) code |= (1 << i);
    end
    return code;
  endfunction

  task automatic start_frame(input int m, input int th);
    reset = 1'b0;
    bus.gray_ready = 1'b0;
    mode = 2'(m);
    thresh = 8'(th);
    repeat (2) @(posedge clk);
    clear_mon();
    #1 reset = 1'b1;
    @(posedge clk);
    #1 bus.gray_ready = 1'b1;
  endtask

  task automatic check_frame(input int m, input int th);
    int exp_req[$];
    int grp[$];
    int idx;
    int last_t;
    for (int r = 1; r < H-1; r++) begin
      for (int c = 1; c < W-1; c++) begin
        grp.push_back(exp_req.size());
        if (c == 1) begin
          for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) exp_req.push_back((r-1+j)*W + c-1+k);
        end else begin
          for (int j = 0; j < 3; j++) exp_req.push_back((r-1+j)*W + c+1);
        end
      end
    end
    chk("n_writes", wr_addr_q.size(), N);
    for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_addr_q[i], i);
      chk($sformatf("wr_data[%0d] m%0d t%0d", i, m, th), wr_data_q[i], exp_code(i / W, i % W, m, th));
    end
    chk("n_reads", req_addr_q.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < req_addr_q.size(); i++)
      chk($sformatf("rd_addr[%0d]", i), req_addr_q[i], exp_req[i]);
    idx = 0;
    for (int r = 1; r < H-1; r++) begin
      for (int c = 1; c < W-1; c++) begin
        if (r*W + c < wr_t_q.size() && grp[idx] < req_t_q.size())
          chk($sformatf("latency(%0d,%0d)", r, c), wr_t_q[r*W + c] - req_t_q[grp[idx]], (c == 1) ? 11 : 5);
        idx++;
      end
    end
    last_t = (wr_t_q.size() > 0) ? wr_t_q[wr_t_q.size()-1] : -100;
    chk("finish_time", fin_t, last_t + 1);
    chk("finish_sticky", finish, 1'b1);
    chk("hold_violations", hold_viol, 0);
    chk("req_during_write", req_in_wr, 0);
  endtask

  task automatic run_frame(input int m, input int th, input bit mid_change);
    int t;
    start_frame(m, th);
    if (mid_change) begin
      repeat (20) @(posedge clk);
      #1;
      mode = 2'($urandom);
      thresh = 8'($urandom);
      bus.gray_ready = 1'b0;
    end
    t = 0;
    while (!finish && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done", finish, 1'b1);
    repeat (10) @(negedge clk);
    check_frame(m, th);
  endtask

  initial begin
    int t;
    bit found;
    bus.gray_ready = 1'b0;
    fill_mem(2);
    clear_mon();

    // Reset values
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gray_addr", bus.gray_addr, 0);
    chk("rst_gray_req", bus.gray_req, 0);
    chk("rst_lbp_addr", bus.lbp_addr, 0);
    chk("rst_lbp_valid", bus.lbp_valid, 0);
    chk("rst_lbp_data", bus.lbp_data, 0);
    chk("rst_finish", finish, 0);

    // Engine waits in IDLE while the grey memory is not ready
    @(posedge clk);
    clear_mon();
    #1 reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_reads", req_addr_q.size(), 0);
    chk("idle_writes", wr_addr_q.size(), 0);
    chk("idle_finish", finish, 0);

    // Flat image, mode 0
    fill_mem(2);
    run_frame(0, 0, 1'b0);

    // Random image, configuration disturbed mid-frame
    fill_mem(0);
    run_frame(0, int'($urandom_range(255, 0)), 1'b1);

    // Thresholded LBP on near-flat and random content
    fill_mem(1);
    run_frame(2, int'($urandom_range(3, 0)), 1'b0);
    fill_mem(0);
    run_frame(2, int'($urandom_range(255, 0)), 1'b1);

    // CS-LBP
    fill_mem(0);
    run_frame(1, int'($urandom_range(40, 0)), 1'b0);
    fill_mem(1);
    run_frame(1, 0, 1'b0);

    // Mode 3 behaves as mode 0
    fill_mem(0);
    run_frame(3, int'($urandom_range(255, 0)), 1'b0);

    // Reset pulled during the SLIDE of pixel (3,4)
    fill_mem(0);
    start_frame(0, 0);
    t = 0;
    found = 1'b0;
    while (t < 2000 && !found) begin
      @(negedge clk);
      t++;
      if (bus.lbp_valid && int'(bus.lbp_addr) == 3*W + 3) found = 1'b1;
    end
    chk("reach_pixel_3_3", found, 1'b1);
    @(posedge clk);
    #2;
    chk("slide_req", bus.gray_req, 1'b1);
    chk("slide_addr", bus.gray_addr, 2*W + 5);
    reset = 1'b0;
    #1;
    chk("async_gray_addr", bus.gray_addr, 0);
    chk("async_gray_req", bus.gray_req, 0);
    chk("async_lbp_addr", bus.lbp_addr, 0);
    chk("async_lbp_valid", bus.lbp_valid, 0);
    chk("async_lbp_data", bus.lbp_data, 0);
    chk("async_finish", finish, 0);
    run_frame(1, int'($urandom_range(20, 0)), 1'b1);
    chk("restart_first_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
